// File: rtl/rx_pkg.sv
// Shared types and constants for the receive-path frame dispatcher.
package rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_FORWARD,
        ST_DISCARD,
        ST_REARM
    } rx_state_e;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] LEN_UNKNOWN   = 16'h1FFF;
    localparam logic [15:0] IPV4_MIN_LEN  = 16'd20;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_IPV4 = 2'b01;
    localparam logic [1:0] SEL_ARP  = 2'b10;

    // Whole 32-bit words the wrapper pushes for a frame: it writes len+4
    // bytes, and a trailing partial word never leaves the FIFO.
    function automatic logic [15:0] len_to_words(input logic [15:0] len);
        logic [15:0] bytes;
        bytes = len + 16'd4;
        return bytes >> 2;
    endfunction

endpackage

// File: rtl/rx_out_reg.sv
// Sink output register: holds a word until the consumer takes it.
module rx_out_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        load_last,
    input  logic        mark_last,
    input  logic        sink_ready,
    output logic [31:0] sink_data,
    output logic        sink_valid,
    output logic        sink_last
);

    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;

    // Next word/valid/last: handshake frees the slot, load refills it,
    // an abort retro-tags a still-held word as the frame's last.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (valid_q && sink_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
        if (mark_last && valid_q && !sink_ready) begin
            last_d = 1'b1;
        end
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
            last_d  = load_last;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign sink_data  = data_q;
    assign sink_valid = valid_q;
    assign sink_last  = last_q;

endmodule

// File: rtl/rx_frame_dispatcher.sv
// Receive-path frame controller: classify, drain to sink or discard, re-arm.
module rx_frame_dispatcher
    import rx_pkg::*;
#(
    parameter int CLEAR_CYCLES = 4,
    parameter int TIMEOUT      = 4096,
    parameter int MAX_LEN      = 1518
) (
    input  logic        clk_100_mhz,
    input  logic        rst_n,
    input  logic        frame_ready,
    input  logic [15:0] frame_len,
    input  logic [15:0] frame_type,
    input  logic [31:0] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        rx_rst_n,
    output logic [31:0] sink_data,
    output logic        sink_valid,
    output logic        sink_last,
    output logic [1:0]  sink_sel,
    input  logic        sink_ready,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count
);

    localparam int          TO_W      = $clog2(TIMEOUT + 1);
    localparam int          CL_W      = $clog2(CLEAR_CYCLES + 1);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    rx_state_e         state_q, state_d;
    logic [15:0]       words_left_q, words_left_d;
    logic              pend_q, pend_d;       // a FORWARD read's data arrives this cycle
    logic [TO_W-1:0]   to_q, to_d;
    logic [CL_W-1:0]   clr_q, clr_d;
    logic [1:0]        sel_q, sel_d;
    logic [15:0]       fc_q, fc_d, dc_q, dc_d;
    logic              ign_q, ign_d;         // first IDLE cycle after REARM
    logic              rx_rst_n_q, rx_rst_n_d;
    logic [15:0]       wl_new;
    logic              load, load_last, mark_last, hs;

    // FSM next state, FIFO strobe and counter updates.
    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        pend_d       = 1'b0;
        to_d         = to_q;
        clr_d        = clr_q;
        sel_d        = sel_q;
        fc_d         = fc_q;
        dc_d         = dc_q;
        ign_d        = (state_q == ST_REARM);
        fifo_rd_en   = 1'b0;
        load         = pend_q;
        load_last    = (words_left_q == 16'd0);
        mark_last    = 1'b0;
        hs           = sink_valid && sink_ready;
        wl_new       = len_to_words(frame_len);

        unique case (state_q)
            ST_IDLE: begin
                // A word held from an aborted frame drains before sink_sel may change.
                if (frame_ready && !ign_q && !sink_valid) state_d = ST_CLASSIFY;
            end
            ST_CLASSIFY: begin
                words_left_d = wl_new;
                to_d         = '0;
                // A zero word count (len wrapped near 16'hFFFF) could never finish.
                if (frame_len == LEN_UNKNOWN || wl_new == 16'd0) begin
                    state_d = ST_DISCARD;
                    dc_d    = dc_q + 16'd1;
                end else if (frame_type == ETH_TYPE_IPV4 &&
                             frame_len >= IPV4_MIN_LEN && frame_len <= MAX_LEN_W) begin
                    sel_d   = SEL_IPV4;
                    state_d = ST_FORWARD;
                end else if (frame_type == ETH_TYPE_ARP) begin
                    sel_d   = SEL_ARP;
                    state_d = ST_FORWARD;
                end else begin
                    state_d = ST_DISCARD;
                    dc_d    = dc_q + 16'd1;
                end
            end
            ST_FORWARD: begin
                fifo_rd_en = !fifo_empty && (words_left_q != 16'd0) && !pend_q &&
                             (!sink_valid || sink_ready);
                if (fifo_rd_en) begin
                    words_left_d = words_left_q - 16'd1;
                    pend_d       = 1'b1;
                end
                if (hs && sink_last) begin
                    fc_d    = fc_q + 16'd1;
                    state_d = ST_DISCARD;
                end else if (fifo_empty && words_left_q != 16'd0) begin
                    if (to_q == TO_W'(TIMEOUT - 1)) begin
                        mark_last = 1'b1;
                        dc_d      = dc_q + 16'd1;
                        clr_d     = '0;
                        state_d   = ST_REARM;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end else begin
                    to_d = '0;
                end
            end
            ST_DISCARD: begin
                if (fifo_empty) begin
                    clr_d   = '0;
                    state_d = ST_REARM;
                end else begin
                    fifo_rd_en = 1'b1;
                end
            end
            ST_REARM: begin
                if (clr_q == CL_W'(CLEAR_CYCLES - 1)) state_d = ST_IDLE;
                else                                   clr_d   = clr_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        rx_rst_n_d = (state_d != ST_REARM);
    end

    // State and control registers, synchronous active-low reset.
    always_ff @(posedge clk_100_mhz) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            words_left_q <= '0;
            pend_q       <= 1'b0;
            to_q         <= '0;
            clr_q        <= '0;
            sel_q        <= SEL_NONE;
            fc_q         <= '0;
            dc_q         <= '0;
            ign_q        <= 1'b0;
            rx_rst_n_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            pend_q       <= pend_d;
            to_q         <= to_d;
            clr_q        <= clr_d;
            sel_q        <= sel_d;
            fc_q         <= fc_d;
            dc_q         <= dc_d;
            ign_q        <= ign_d;
            rx_rst_n_q   <= rx_rst_n_d;
        end
    end

    rx_out_reg u_out (
        .clk        (clk_100_mhz),
        .rst_n      (rst_n),
        .load       (load),
        .load_data  (fifo_data),
        .load_last  (load_last),
        .mark_last  (mark_last),
        .sink_ready (sink_ready),
        .sink_data  (sink_data),
        .sink_valid (sink_valid),
        .sink_last  (sink_last)
    );

    assign rx_rst_n    = rx_rst_n_q;
    assign sink_sel    = sel_q;
    assign frame_count = fc_q;
    assign drop_count  = dc_q;

endmodule
